conv_25d_stream: RTL and testbench
==================================

Name: conv_25d_stream

Overview:
Streaming 2.5D convolution layer, the successor to the fixed-geometry 2.5D convolution block. Its features:
- Accepts a raster-ordered pixel stream with a valid qualifier.
- Builds K×K×Z_DEPTH windows from internal line buffers.
- Computes NUM_TREES kernel dot-products plus a per-tree bias.
- Emits results only for windows fully inside the frame, with out_valid and out_last.
- Sits between a pixel source or previous layer and the pooling or next convolution layer.

Parameters:
NUM_TREES, 2, number of kernels (output channels) computed in parallel
Z_DEPTH, 4, input channels per pixel
K_SIZE, 4, kernel is K_SIZE×K_SIZE (≥2)
IMG_WIDTH, 6, pixels per row (>K_SIZE)
IMG_HEIGHT, 6, rows per frame (≥K_SIZE)
PIX_W, 8, unsigned pixel width
W_W, 8, signed two's-complement weight width
ACC_W, 32, signed accumulator/output width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pixel_valid  in  1  pixel_vector_in accepted on this edge when high
pixel_vector_in  in  PIX_W*Z_DEPTH  channel z at [z*PIX_W +: PIX_W]
kernel  in  W_W*NUM_TREES*K_SIZE*K_SIZE*Z_DEPTH  weight(t,z,i,j) at [((z*NUM_TREES+t)*K*K + i*K + j)*W_W +: W_W]; i=0 newest row, j=0 newest column; quasi-static
bias  in  ACC_W*NUM_TREES  signed bias for tree t at [t*ACC_W +: ACC_W]; quasi-static
pixel_vector_out  out  ACC_W*NUM_TREES  tree t result at [t*ACC_W +: ACC_W]
out_valid  out  1  pixel_vector_out holds a valid window result this cycle
out_last  out  1  with out_valid, marks last window of the frame

Behaviour:
- Reset (sync, active-high, dominant over pixel_valid):
  - col/row counters = 0.
  - Pipeline valid bits, out_valid and out_last = 0.
  - pixel_vector_out = 0.
  - Line-buffer contents are not cleared.
- Accepted pixel (pixel_valid=1):
  - Shifts into the window/line-buffer structure.
  - col increments, wrapping IMG_WIDTH-1→0 with row++.
  - row wraps IMG_HEIGHT-1→0 at frame end.
- Window validity:
  - The pixel accepted at (row,col) completes the window of rows row-K+1..row, cols col-K+1..col.
  - Valid iff row≥K-1 and col≥K-1.
  - Windows straddling a row edge are never flagged valid, so there is no wrap-around output.
- Pipeline (LATENCY=3, free-running, with a valid bit per stage):
  - S1: signed products. Pixel is zero-extended to PIX_W+1 and multiplied by the weight.
  - S2: per-(tree,z) K×K sum.
  - S3: sum over z plus bias, written to pixel_vector_out.
- Timing: a window completed by the pixel accepted at edge E produces out_valid=1 for exactly one cycle after edge E+3. out_last=1 on that cycle iff the pixel was (IMG_HEIGHT-1, IMG_WIDTH-1).
- Stalls: pixel_valid=0 cycles do not advance counters or the window. In-flight results still drain, and the bubble propagates as out_valid=0. Results are independent of stall pattern.
- Arithmetic:
  - All sums are sign-extended to ACC_W.
  - Overflow wraps modulo 2^ACC_W; no saturation.
- Output hold: when out_valid=0, pixel_vector_out holds its last value.
- Back-to-back frames need no gap. Stale line-buffer rows from the previous frame are never used because of the row≥K-1 condition.
- Reset mid-frame: in-flight results are discarded (no out_valid after reset). The next accepted pixel is (0,0).
- Kernel/bias changes take effect for windows whose S1/S3 sample after the change. Changing them mid-frame is allowed but not coherent per window.

Optional Feature:
CONV_RELU_EN:
- Defined: S3 output is clamped to 0 if negative, before registering (ReLU fused into the layer).
- Undefined: raw signed sum is output.
- out_valid/out_last timing is identical in both builds.

Test Plan:
Bench configuration: K_SIZE=2, IMG_WIDTH=4, IMG_HEIGHT=4, Z_DEPTH=2, NUM_TREES=2. Tree 1 weights all +1, bias 0. Tree 2 weights all 0xFF (−1), bias 5. Pixel counter 0..15 driven on both channels.
1. Continuous stream, no stalls -> 9 outputs. Tree 1 sequence 20,28,36,52,60,68,84,92,100. Tree 2 sequence −15,−23,−31,−47,−55,−63,−79,−87,−95. First out_valid 3 cycles after pixel 5 is accepted; out_last only with 100/−95.
2. Same stream with pixel_valid low for 3 cycles after pixels 6 and 11 -> identical value sequence. out_valid count 9. Gaps propagate and no duplicates appear.
3. Two frames back-to-back, the second with pixels 16..31 -> frame 2 tree 1 first result is 2*(16+17+20+21)=148. No output is generated from pixels 16–20. Exactly 2 out_last pulses.
4. Reset asserted one cycle after pixel 9 is accepted, then stream restarts at 0 -> no out_valid from the aborted windows. First output is again 20/−15.
5. CONV_RELU_EN defined, scenario 1 -> tree 1 unchanged, tree 2 all 0. With bias 60: tree 2 outputs 40,32,24,8,0,0,0,0,0.
6. Overflow: ACC_W=16, weights 127, pixels 255, bias 0x7FFF -> output equals the sum truncated modulo 2^16, interpreted signed. No saturation.

Source files
------------

// File: rtl/conv_25d_stream.sv
// ---------------------------------------------------------------------------
// conv_25d_stream
//
// Streaming 2.5D convolution layer. Raster-ordered pixel vectors (Z_DEPTH
// channels each) are shifted into a line-buffer delay chain. Every accepted
// pixel that completes a K_SIZE x K_SIZE window lying fully inside the frame
// launches one result through a 3-stage pipeline that computes NUM_TREES
// dot-products plus a per-tree bias.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high reset (dominant)
//   pixel_valid      in   pixel_vector_in accepted on this edge when high
//   pixel_vector_in  in   channel z at [z*PIX_W +: PIX_W], unsigned
//   kernel           in   weight(t,z,i,j) at
//                         [((z*NUM_TREES+t)*K*K + i*K + j)*W_W +: W_W],
//                         i=0 newest row, j=0 newest column, signed
//   bias             in   tree t bias at [t*ACC_W +: ACC_W], signed
//   pixel_vector_out out  tree t result at [t*ACC_W +: ACC_W]; holds when
//                         out_valid is low
//   out_valid        out  one-cycle pulse per valid window result
//   out_last         out  with out_valid, marks last window of the frame
//
// Handshake: the input side is valid-only (no ready). A pixel is consumed on
// every rising edge where pixel_valid is high and reset is low; the output
// side is a valid-only pulse with no back-pressure.
//
// Optional build macro: CONV_RELU_EN -- when defined, negative final sums are
// clamped to zero before being registered. Output timing is identical.
// ---------------------------------------------------------------------------
module conv_25d_stream #(
  parameter int NUM_TREES  = 2,
  parameter int Z_DEPTH    = 4,
  parameter int K_SIZE     = 4,
  parameter int IMG_WIDTH  = 6,
  parameter int IMG_HEIGHT = 6,
  parameter int PIX_W      = 8,
  parameter int W_W        = 8,
  parameter int ACC_W      = 32
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          pixel_valid,
  input  logic [PIX_W*Z_DEPTH-1:0]                      pixel_vector_in,
  input  logic [W_W*NUM_TREES*K_SIZE*K_SIZE*Z_DEPTH-1:0] kernel,
  input  logic [ACC_W*NUM_TREES-1:0]                    bias,
  output logic [ACC_W*NUM_TREES-1:0]                    pixel_vector_out,
  output logic                                          out_valid,
  output logic                                          out_last
);

  // Delay chain long enough that tap (i*IMG_WIDTH + j) holds the pixel
  // i rows and j columns older than the newest one.
  localparam int TAPS   = (K_SIZE - 1) * IMG_WIDTH + K_SIZE;
  localparam int VEC_W  = PIX_W * Z_DEPTH;
  localparam int PROD_W = PIX_W + 1 + W_W;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K_SIZE - 1);

  // -------------------------------------------------------------------------
  // Position counters and pipeline control
  // -------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Stage valid/last bits: win = window captured (edge E), prod = S1,
  // sum = S2; the S3 stage is the registered output itself.
  logic win_valid_q, win_last_q;
  logic prod_valid_q, prod_last_q;
  logic sum_valid_q, sum_last_q;

  logic win_ok, frame_end;

  // The counters describe the pixel being accepted on this edge.
  assign win_ok    = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line-buffer delay chain (not reset: stale rows are never selected
  // because the first K_SIZE-1 rows of a frame never form a valid window)
  // -------------------------------------------------------------------------
  logic [VEC_W-1:0] line_q [TAPS];

  always_ff @(posedge clock) begin
    if (!reset && pixel_valid) begin
      line_q[0] <= pixel_vector_in;
      for (int k = 1; k < TAPS; k++) begin
        line_q[k] <= line_q[k-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // S1: signed products, pixel zero-extended to PIX_W+1 bits
  // -------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_d [NUM_TREES][Z_DEPTH][K_SIZE][K_SIZE];
  logic signed [PROD_W-1:0] prod_q [NUM_TREES][Z_DEPTH][K_SIZE][K_SIZE];

  always_comb begin
    logic signed [PROD_W-1:0] px_ext;
    logic signed [PROD_W-1:0] wt_ext;
    px_ext = '0;
    wt_ext = '0;
    for (int t = 0; t < NUM_TREES; t++) begin
      for (int z = 0; z < Z_DEPTH; z++) begin
        for (int i = 0; i < K_SIZE; i++) begin
          for (int j = 0; j < K_SIZE; j++) begin
            px_ext = PROD_W'($signed({1'b0, line_q[i*IMG_WIDTH + j][z*PIX_W +: PIX_W]}));
            wt_ext = PROD_W'($signed(kernel[((z*NUM_TREES + t)*K_SIZE*K_SIZE
                                              + i*K_SIZE + j)*W_W +: W_W]));
            prod_d[t][z][i][j] = px_ext * wt_ext;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    prod_q <= prod_d;
  end

  // -------------------------------------------------------------------------
  // S2: per-(tree, channel) K x K sum, sign-extended to ACC_W
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] sum_d [NUM_TREES][Z_DEPTH];
  logic signed [ACC_W-1:0] sum_q [NUM_TREES][Z_DEPTH];

  always_comb begin
    for (int t = 0; t < NUM_TREES; t++) begin
      for (int z = 0; z < Z_DEPTH; z++) begin
        sum_d[t][z] = '0;
        for (int i = 0; i < K_SIZE; i++) begin
          for (int j = 0; j < K_SIZE; j++) begin
            sum_d[t][z] = sum_d[t][z] + ACC_W'(prod_q[t][z][i][j]);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    sum_q <= sum_d;
  end

  // -------------------------------------------------------------------------
  // S3: sum over channels plus bias (optionally rectified)
  // -------------------------------------------------------------------------
  logic [ACC_W*NUM_TREES-1:0] out_d;

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc   = '0;
    out_d = '0;
    for (int t = 0; t < NUM_TREES; t++) begin
      acc = $signed(bias[t*ACC_W +: ACC_W]);
      for (int z = 0; z < Z_DEPTH; z++) begin
        acc = acc + sum_q[t][z];
      end
`ifdef CONV_RELU_EN
      if (acc[ACC_W-1]) begin
        acc = '0;
      end
`else
`endif
      out_d[t*ACC_W +: ACC_W] = acc;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q            <= '0;
      row_q            <= '0;
      win_valid_q      <= 1'b0;
      win_last_q       <= 1'b0;
      prod_valid_q     <= 1'b0;
      prod_last_q      <= 1'b0;
      sum_valid_q      <= 1'b0;
      sum_last_q       <= 1'b0;
      out_valid        <= 1'b0;
      out_last         <= 1'b0;
      pixel_vector_out <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= pixel_valid && win_ok;
      win_last_q   <= pixel_valid && frame_end;
      prod_valid_q <= win_valid_q;
      prod_last_q  <= win_last_q;
      sum_valid_q  <= prod_valid_q;
      sum_last_q   <= prod_last_q;
      out_valid    <= sum_valid_q;
      out_last     <= sum_valid_q && sum_last_q;
      if (sum_valid_q) begin
        pixel_vector_out <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_conv_25d_stream.sv
// ---------------------------------------------------------------------------
// tb_conv_25d_stream
//
// Directed bench for conv_25d_stream in a small geometry (K=2, 4x4 frame,
// 2 channels, 2 trees). Tree 0 weights all +1 with bias 0; tree 1 weights all
// -1 with bias 5. The pixel value p is driven on both channels. A second,
// narrow instance (ACC_W=16, one tree) checks modular wrap-around.
// ---------------------------------------------------------------------------
module tb_conv_25d_stream;

  localparam int T  = 2;
  localparam int Z  = 2;
  localparam int K  = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int WW = 8;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  int   cyc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                      pixel_valid;
  logic [PW*Z-1:0]           pixel_vector_in;
  logic [WW*T*K*K*Z-1:0]     kernel;
  logic [AW*T-1:0]           bias;
  logic [AW*T-1:0]           pixel_vector_out;
  logic                      out_valid;
  logic                      out_last;

  conv_25d_stream #(
    .NUM_TREES(T), .Z_DEPTH(Z), .K_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PIX_W(PW), .W_W(WW), .ACC_W(AW)
  ) u_dut (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid),
    .pixel_vector_in(pixel_vector_in), .kernel(kernel), .bias(bias),
    .pixel_vector_out(pixel_vector_out), .out_valid(out_valid),
    .out_last(out_last)
  );

  // Narrow accumulator instance: 8 products of 127*255 plus 0x7FFF.
  logic [15:0] ovf_out;
  logic        ovf_valid;
  logic        ovf_last;

  conv_25d_stream #(
    .NUM_TREES(1), .Z_DEPTH(Z), .K_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PIX_W(PW), .W_W(WW), .ACC_W(16)
  ) u_ovf (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid),
    .pixel_vector_in(16'hFFFF), .kernel({8{8'h7F}}), .bias(16'h7FFF),
    .pixel_vector_out(ovf_out), .out_valid(ovf_valid), .out_last(ovf_last)
  );

  // ---------------- monitor ----------------
  logic [31:0] obs_t0[$];
  logic [31:0] obs_t1[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  int          ovf_count;

  always @(negedge clock) begin
    if (out_valid) begin
      obs_t0.push_back(pixel_vector_out[31:0]);
      obs_t1.push_back(pixel_vector_out[63:32]);
      obs_last.push_back(out_last);
      obs_cyc.push_back(cyc);
    end
    if (ovf_valid) ovf_count <= ovf_count + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;

  // Hand-computed per-frame expectations (windows ending at pixels
  // 5,6,7,9,10,11,13,14,15 of a 0..15 frame).
  int exp_t0[9] = '{20, 28, 36, 52, 60, 68, 84, 92, 100};
  int exp_t1[9] = '{-15, -23, -31, -47, -55, -63, -79, -87, -95};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] want_t1(input int i, input int delta);
`ifdef CONV_RELU_EN
    want_t1 = 32'd0;
`else
    want_t1 = 32'(exp_t1[i] - delta);
`endif
  endfunction

  // Compare 9 observed results starting at index start against the
  // per-frame table shifted by delta (frame with pixel offset base gives
  // delta = 8*base for tree 0 and -8*base for tree 1).
  task automatic check_frame(input string tag, input int start, input int delta);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_t0"}, (start + i < obs_t0.size()) ? obs_t0[start+i] : 32'hxxxxxxxx,
            32'(exp_t0[i] + delta));
      check({tag, "_t1"}, (start + i < obs_t1.size()) ? obs_t1[start+i] : 32'hxxxxxxxx,
            want_t1(i, delta));
    end
  endtask

  function automatic int count_last();
    count_last = 0;
    foreach (obs_last[i]) if (obs_last[i]) count_last++;
  endfunction

  task automatic clear_obs();
    obs_t0.delete();
    obs_t1.delete();
    obs_last.delete();
    obs_cyc.delete();
  endtask

  // ---------------- driver tasks ----------------
  int acc5_cyc;

  task automatic send_pixel(input int p);
    pixel_valid     = 1'b1;
    pixel_vector_in = {8'(p), 8'(p)};
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
    if (p % 16 == 5) acc5_cyc = cyc;
  endtask

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pixel_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Send pixels base..base+n-1, idling 3 cycles after pixels sa and sb.
  task automatic send_frame(input int base, input int n, input int sa, input int sb);
    for (int p = 0; p < n; p++) begin
      send_pixel(base + p);
      if (p == sa || p == sb) idle(3);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp           = 0;
    n_err           = 0;
    cyc             = 0;
    ovf_count       = 0;
    reset           = 1'b1;
    pixel_valid     = 1'b0;
    pixel_vector_in = '0;
    acc5_cyc        = 0;
    for (int z = 0; z < Z; z++) begin
      for (int e = 0; e < K*K; e++) begin
        kernel[((z*T + 0)*K*K + e)*WW +: WW] = 8'h01;
        kernel[((z*T + 1)*K*K + e)*WW +: WW] = 8'hFF;
      end
    end
    bias = {32'd5, 32'd0};
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_out_t0", pixel_vector_out[31:0],  32'd0);
    check("rst_out_t1", pixel_vector_out[63:32], 32'd0);

    // 1. Continuous frame
    clear_obs();
    send_frame(0, 16, -1, -1);
    idle(6);
    check("s1_count", 32'(obs_t0.size()), 32'd9);
    check_frame("s1", 0, 0);
    check("s1_latency", (obs_cyc.size() > 0) ? 32'(obs_cyc[0] - acc5_cyc) : 32'hxxxxxxxx, 32'd3);
    check("s1_adjacent", (obs_cyc.size() > 1) ? 32'(obs_cyc[1] - obs_cyc[0]) : 32'hxxxxxxxx, 32'd1);
    check("s1_last_cnt", 32'(count_last()), 32'd1);
    check("s1_last_pos", (obs_last.size() > 8) ? 32'(obs_last[8]) : 32'hxxxxxxxx, 32'd1);
    check("s1_hold_valid", 32'(out_valid), 32'd0);
    check("s1_hold_t0", pixel_vector_out[31:0], 32'd100);
`ifdef CONV_RELU_EN
    check("s1_hold_t1", pixel_vector_out[63:32], 32'd0);
`else
    check("s1_hold_t1", pixel_vector_out[63:32], 32'hFFFFFFA1);
`endif
    check("ovf_count", 32'(ovf_count), 32'd9);
    check("ovf_value", {16'd0, ovf_out}, 32'h00007407);

    // 2. Same frame with stalls after pixels 6 and 11
    clear_obs();
    send_frame(0, 16, 6, 11);
    idle(6);
    check("s2_count", 32'(obs_t0.size()), 32'd9);
    check_frame("s2", 0, 0);
    check("s2_gap", (obs_cyc.size() > 2) ? 32'(obs_cyc[2] - obs_cyc[1]) : 32'hxxxxxxxx, 32'd4);
    check("s2_last_cnt", 32'(count_last()), 32'd1);

    // 3. Two frames back-to-back, second carries pixels 16..31
    clear_obs();
    send_frame(0, 16, -1, -1);
    send_frame(16, 16, -1, -1);
    idle(6);
    check("s3_count", 32'(obs_t0.size()), 32'd18);
    check_frame("s3_f1", 0, 0);
    check_frame("s3_f2", 9, 128);
    check("s3_f2_first", (obs_t0.size() > 9) ? obs_t0[9] : 32'hxxxxxxxx, 32'd148);
    check("s3_last_cnt", 32'(count_last()), 32'd2);
    check("s3_last_pos", (obs_last.size() > 17) ? 32'(obs_last[17]) : 32'hxxxxxxxx, 32'd1);

    // 4. Reset one cycle after pixel 9, then restart from pixel 0
    clear_obs();
    send_frame(0, 10, -1, -1);
    do_reset();
    check("s4_pre_count", 32'(obs_t0.size()), 32'd2);
    clear_obs();
    idle(6);
    check("s4_flush", 32'(obs_t0.size()), 32'd0);
    check("s4_rst_out", pixel_vector_out[31:0], 32'd0);
    send_frame(0, 16, -1, -1);
    idle(6);
    check("s4_count", 32'(obs_t0.size()), 32'd9);
    check_frame("s4", 0, 0);
    check("s4_last_cnt", 32'(count_last()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
